// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register: latches decoded controls, forwards from MEM/WB, builds ALU operands.
// Optional macro IDEX_FORWARD_EN enables forwarding and stall-time operand refresh.
module id_exe_stage_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_inst,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [3:0]    id_oper,
  input  logic [1:0]    id_a_sel,
  input  logic [1:0]    id_b_sel,
  input  logic          id_wb_en,
  input  logic [4:0]    id_wb_addr,
  input  logic          id_mem_ren,
  input  logic          id_mem_wen,
  input  logic          mem_fwd_en,
  input  logic [4:0]    mem_fwd_addr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          exe_valid,
  output logic [DW-1:0] exe_inst,
  output logic [DW-1:0] exe_pc,
  output logic [DW-1:0] exe_a,
  output logic [DW-1:0] exe_b,
  output logic [3:0]    exe_oper,
  output logic [DW-1:0] exe_store_data,
  output logic          exe_wb_en,
  output logic          exe_mem_ren,
  output logic          exe_mem_wen,
  output logic [4:0]    exe_wb_addr,
  output logic          load_use_hazard
);

  logic [4:0]    id_rs, id_rt;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic [DW-1:0] a_nxt, b_nxt;
  logic [1:0]    a_sel_p0, b_sel_p0;

  assign id_rs = id_inst[25:21];
  assign id_rt = id_inst[20:16];

  // MEM result beats WB result; $0 is never forwarded.
  function automatic logic [DW-1:0] fwd_pick(
    input logic          m_en,
    input logic [4:0]    m_addr,
    input logic [DW-1:0] m_data,
    input logic          w_en,
    input logic [4:0]    w_addr,
    input logic [DW-1:0] w_data,
    input logic [4:0]    r,
    input logic [DW-1:0] rf);
    if (m_en && m_addr == r && r != 5'd0)      return m_data;
    else if (w_en && w_addr == r && r != 5'd0) return w_data;
    else                                       return rf;
  endfunction

  function automatic logic [DW-1:0] op_a(input logic [1:0] sel,
                                         input logic [DW-1:0] rs_v,
                                         input logic [4:0] shamt);
    case (sel)
      2'd0:    return rs_v;
      2'd1:    return {{(DW-5){1'b0}}, shamt};
      2'd2:    return {{(DW-5){1'b0}}, rs_v[4:0]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] op_b(input logic [1:0] sel,
                                         input logic [DW-1:0] rt_v,
                                         input logic [15:0] imm,
                                         input logic [DW-1:0] pc);
    logic signed [15:0] imm_s;
    logic signed [DW-1:0] imm_sx;
    imm_s  = $signed(imm);
    imm_sx = DW'(imm_s);
    case (sel)
      2'd0:    return rt_v;
      2'd1:    return imm_sx;
      2'd2:    return {{(DW-16){1'b0}}, imm};
      default: return pc + DW'(8);
    endcase
  endfunction

`ifdef IDEX_FORWARD_EN
  assign rs_fwd = fwd_pick(mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                           wb_en, wb_addr, wb_data, id_rs, id_rs_data);
  assign rt_fwd = fwd_pick(mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                           wb_en, wb_addr, wb_data, id_rt, id_rt_data);
  assign load_use_hazard = exe_valid & exe_mem_ren & (exe_wb_addr != 5'd0) & id_valid &
                           ((exe_wb_addr == id_rs) | (exe_wb_addr == id_rt));
`else
  logic unused_nofwd;
  logic ex_hit, mem_hit;
  assign rs_fwd = id_rs_data;
  assign rt_fwd = id_rt_data;
  assign unused_nofwd = ^{mem_fwd_data, wb_en, wb_addr, wb_data, a_sel_p0, b_sel_p0,
                          fwd_pick(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, '0)};
  assign ex_hit  = exe_wb_en & (exe_wb_addr != 5'd0) &
                   ((exe_wb_addr == id_rs) | (exe_wb_addr == id_rt));
  assign mem_hit = mem_fwd_en & (mem_fwd_addr != 5'd0) &
                   ((mem_fwd_addr == id_rs) | (mem_fwd_addr == id_rt));
  assign load_use_hazard = id_valid & ((exe_valid & exe_mem_ren & ex_hit) | ex_hit | mem_hit);
`endif

  assign a_nxt = op_a(id_a_sel, rs_fwd, id_inst[10:6]);
  assign b_nxt = op_b(id_b_sel, rt_fwd, id_inst[15:0], id_pc);

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      exe_valid      <= 1'b0;
      exe_inst       <= '0;
      exe_pc         <= '0;
      exe_a          <= '0;
      exe_b          <= '0;
      exe_oper       <= '0;
      exe_store_data <= '0;
      exe_wb_en      <= 1'b0;
      exe_mem_ren    <= 1'b0;
      exe_mem_wen    <= 1'b0;
      exe_wb_addr    <= '0;
      a_sel_p0       <= '0;
      b_sel_p0       <= '0;
    end else if (stall) begin
`ifdef IDEX_FORWARD_EN
      // Held operands pick up a write-back that lands while EX is frozen.
      if (exe_valid && wb_en && wb_addr != 5'd0) begin
        if (wb_addr == exe_inst[25:21] && (a_sel_p0 == 2'd0 || a_sel_p0 == 2'd2))
          exe_a <= op_a(a_sel_p0, wb_data, exe_inst[10:6]);
        if (wb_addr == exe_inst[20:16]) begin
          exe_store_data <= wb_data;
          if (b_sel_p0 == 2'd0) exe_b <= wb_data;
        end
      end
`endif
    end else begin
      exe_valid      <= 1'b1;
      exe_inst       <= id_inst;
      exe_pc         <= id_pc;
      exe_a          <= a_nxt;
      exe_b          <= b_nxt;
      exe_oper       <= id_oper;
      exe_store_data <= rt_fwd;
      exe_wb_en      <= id_wb_en;
      exe_mem_ren    <= id_mem_ren;
      exe_mem_wen    <= id_mem_wen;
      exe_wb_addr    <= id_wb_addr;
      a_sel_p0       <= id_a_sel;
      b_sel_p0       <= id_b_sel;
    end
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg; expectations follow IDEX_FORWARD_EN when defined.
module tb_id_exe_stage_reg;

`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_inst, id_pc, id_rs_data, id_rt_data;
  logic [3:0]  id_oper;
  logic [1:0]  id_a_sel, id_b_sel;
  logic        id_wb_en, id_mem_ren, id_mem_wen;
  logic [4:0]  id_wb_addr;
  logic        mem_fwd_en, wb_en;
  logic [4:0]  mem_fwd_addr, wb_addr;
  logic [31:0] mem_fwd_data, wb_data;
  logic        exe_valid, exe_wb_en, exe_mem_ren, exe_mem_wen, load_use_hazard;
  logic [31:0] exe_inst, exe_pc, exe_a, exe_b, exe_store_data;
  logic [3:0]  exe_oper;
  logic [4:0]  exe_wb_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DW(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_oper(id_oper),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_wb_en(id_wb_en),
    .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exe_valid(exe_valid), .exe_inst(exe_inst), .exe_pc(exe_pc),
    .exe_a(exe_a), .exe_b(exe_b), .exe_oper(exe_oper),
    .exe_store_data(exe_store_data), .exe_wb_en(exe_wb_en),
    .exe_mem_ren(exe_mem_ren), .exe_mem_wen(exe_mem_wen),
    .exe_wb_addr(exe_wb_addr), .load_use_hazard(load_use_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [3:0] oper, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic wben, input logic [4:0] wba,
                        input logic ren, input logic wen);
    id_valid = 1'b1; id_inst = inst; id_pc = pc; id_rs_data = rsd; id_rt_data = rtd;
    id_oper = oper; id_a_sel = asel; id_b_sel = bsel; id_wb_en = wben;
    id_wb_addr = wba; id_mem_ren = ren; id_mem_wen = wen;
  endtask

  task automatic no_fwd();
    mem_fwd_en = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = '0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    no_fwd();
    tick(); tick();
    chk("reset_valid", {31'b0, exe_valid}, 32'd0);
    chk("reset_inst", exe_inst, 32'd0);
    rst = 1'b0;

    // addi $3,$1,-4
    set_id(32'h2023FFFC, 32'h00400000, 32'd10, 32'd0, 4'd2, 2'd0, 2'd1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    chk("addi_a", exe_a, 32'd10);
    chk("addi_b", exe_b, 32'hFFFFFFFC);
    chk("addi_valid", {31'b0, exe_valid}, 32'd1);
    chk("addi_oper", {28'b0, exe_oper}, 32'd2);

    // add $6,$3,$0 right behind a non-load writing $3
    set_id(32'h00603020, 32'h00400004, 32'd1, 32'd0, 4'd2, 2'd0, 2'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    chk("haz_ex_nonload", {31'b0, load_use_hazard}, FWD ? 32'd0 : 32'd1);

    // add $6,$5,$0 with MEM and WB both hitting $5
    set_id(32'h00A03020, 32'h00400004, 32'd1, 32'd0, 4'd2, 2'd0, 2'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    mem_fwd_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'd7;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd9;
    tick();
    chk("fwd_mem_prio", exe_a, FWD ? 32'd7 : 32'd1);

    mem_fwd_addr = 5'd6;
    tick();
    chk("fwd_wb", exe_a, FWD ? 32'd9 : 32'd1);

    // rs=$0 is never forwarded
    set_id(32'h00003020, 32'h00400008, 32'h11, 32'd0, 4'd2, 2'd0, 2'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    mem_fwd_addr = 5'd0; wb_addr = 5'd0;
    tick();
    chk("fwd_r0", exe_a, 32'h11);
    no_fwd();

    // sll $2,$3,3
    set_id(32'h000310C0, 32'h0040000C, 32'h0, 32'h80, 4'd5, 2'd1, 2'd0, 1'b1, 5'd2, 1'b0, 1'b0);
    tick();
    chk("sll_a", exe_a, 32'd3);
    chk("sll_b", exe_b, 32'h80);

    // sllv $2,$3,$5
    set_id(32'h00A31004, 32'h00400010, 32'h23, 32'h80, 4'd5, 2'd2, 2'd0, 1'b1, 5'd2, 1'b0, 1'b0);
    tick();
    chk("sllv_a", exe_a, 32'd3);

    // sw $7,4($2) with rt forwarded from MEM
    set_id(32'hAC470004, 32'h00400014, 32'h200, 32'h100, 4'd2, 2'd0, 2'd1, 1'b0, 5'd0, 1'b0, 1'b1);
    mem_fwd_en = 1'b1; mem_fwd_addr = 5'd7; mem_fwd_data = 32'h777;
    tick();
    chk("sw_store", exe_store_data, FWD ? 32'h777 : 32'h100);
    chk("sw_b", exe_b, 32'd4);
    chk("sw_wen", {31'b0, exe_mem_wen}, 32'd1);
    no_fwd();

    // lw $4,0($4) into EX
    set_id(32'h8C840000, 32'h00400018, 32'h10, 32'h33, 4'd2, 2'd0, 2'd1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    chk("lw_a", exe_a, 32'h10);
    set_id(32'h00A63020, 32'h0040001C, 32'd0, 32'd0, 4'd2, 2'd0, 2'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    chk("haz_none", {31'b0, load_use_hazard}, 32'd0);
    id_inst = 32'h00803020;
    #1;
    chk("haz_loaduse", {31'b0, load_use_hazard}, 32'd1);
    mem_fwd_en = 1'b1; mem_fwd_addr = 5'd6;
    #1;
    chk("haz_mem_dest", {31'b0, load_use_hazard}, 32'd1);
    mem_fwd_en = 1'b0; mem_fwd_addr = 5'd0;

    // stall one cycle while WB writes $4
    stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    tick();
    stall = 1'b0; no_fwd();
    chk("stall_inst_held", exe_inst, 32'h8C840000);
    chk("refresh_a", exe_a, FWD ? 32'h55 : 32'h10);
    chk("refresh_store", exe_store_data, FWD ? 32'h55 : 32'h33);
    chk("refresh_b_imm", exe_b, 32'd0);

    // flush and stall together
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", {31'b0, exe_valid}, 32'd0);
    chk("flush_wb_en", {31'b0, exe_wb_en}, 32'd0);
    chk("flush_mem_wen", {31'b0, exe_mem_wen}, 32'd0);
    chk("flush_inst", exe_inst, 32'd0);

    // jal: b = pc+8, wrapping at 2^32
    set_id(32'h0C100004, 32'h00400010, 32'd0, 32'd0, 4'd2, 2'd3, 2'd3, 1'b1, 5'd31, 1'b0, 1'b0);
    tick();
    chk("jal_b", exe_b, 32'h00400018);
    chk("jal_a_zero", exe_a, 32'd0);
    id_pc = 32'hFFFFFFFC;
    tick();
    chk("jal_b_wrap", exe_b, 32'h00000004);

    // invalid ID loads a bubble
    id_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'b0, exe_valid}, 32'd0);
    chk("bubble_pc", exe_pc, 32'd0);

    // reset during stall
    set_id(32'h2023FFFC, 32'h00400000, 32'd10, 32'd0, 4'd2, 2'd0, 2'd1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", {31'b0, exe_valid}, 32'd1);
    stall = 1'b1; rst = 1'b1;
    tick();
    stall = 1'b0; rst = 1'b0;
    chk("rst_stall_valid", {31'b0, exe_valid}, 32'd0);
    chk("rst_stall_b", exe_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register and operand-preparation stage between instruction decode and the ALU in the pipelined MIPS CPU.
- Latches decoded control and register operands, resolves RAW hazards by forwarding from the MEM and WB stages, and builds the final ALU operands a, b, oper and inst.
- Honours pipeline stall and flush requests from the hazard and interrupt controller.
- Refreshes held operands from WB while stalled, so write-backs are not lost.

Parameters:
- DW, 32, datapath width (fixed at 32 for MIPS; no other value is supported)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage contents this cycle
- flush  in  1  replace stage contents with a bubble (interrupt, eret, branch squash)
- id_valid  in  1  ID holds a real instruction
- id_inst  in  32  instruction word (rs=[25:21], rt=[20:16], shamt=[10:6], imm=[15:0])
- id_pc  in  32  PC of the instruction
- id_rs_data, id_rt_data  in  32 each  register file read data
- id_oper  in  4  ALU operation code (EXE_ALU_* encoding)
- id_a_sel  in  2  0=rs, 1=zero-ext shamt, 2=rs[4:0] zero-ext, 3=zero
- id_b_sel  in  2  0=rt, 1=sign-ext imm, 2=zero-ext imm, 3=id_pc+8
- id_wb_en  in  1  instruction writes a GPR
- id_wb_addr  in  5  destination register
- id_mem_ren, id_mem_wen  in  1 each  load / store
- mem_fwd_en  in  1  MEM-stage instruction writes a GPR
- mem_fwd_addr  in  5  MEM-stage destination
- mem_fwd_data  in  32  MEM-stage result
- wb_en  in  1  WB-stage instruction writes a GPR
- wb_addr  in  5  WB-stage destination
- wb_data  in  32  WB-stage result
- exe_valid  out  1  EX holds a real instruction
- exe_inst, exe_pc  out  32 each  to ALU / later stages
- exe_a, exe_b  out  32 each  ALU operands
- exe_oper  out  4  ALU operation code
- exe_store_data  out  32  forwarded rt value for stores
- exe_wb_en, exe_mem_ren, exe_mem_wen  out  1 each  controls
- exe_wb_addr  out  5  destination register
- load_use_hazard  out  1  combinational: request stall of ID

Behaviour:
- Update priority each rising edge: rst > flush > stall > load.
- Reset and flush produce a bubble: every output register = 0, so exe_inst=0 (NOP) and exe_oper=0.
- Stall without flush: all registers hold, except operand refresh (below).
- Load: all outputs take the prepared ID values when id_valid=1. When id_valid=0, a bubble is loaded.
- Latency: one cycle from ID inputs to exe_* outputs.
- Forwarding for rs and rt, per source register r:
  - Source = mem_fwd_data if mem_fwd_en and mem_fwd_addr==r and r!=0.
  - Else wb_data if wb_en and wb_addr==r and r!=0.
  - Else register file data.
  - MEM has priority over WB.
- Operand A:
  - sel0 = forwarded rs
  - sel1 = {27'b0, shamt}
  - sel2 = {27'b0, forwarded rs[4:0]}
  - sel3 = 0
- Operand B:
  - sel0 = forwarded rt
  - sel1 = {{16{imm[15]}}, imm}
  - sel2 = {16'b0, imm}
  - sel3 = id_pc+8, modulo 2^32
- exe_store_data is always the forwarded rt.
- Operand refresh during stall: when stall=1, flush=0, exe_valid=1 and wb_en=1 with wb_addr!=0, WB data is written into the held operand:
  - If wb_addr == exe_inst rs and exe a_sel was 0 or 2, reload exe_a, applying the same selection.
  - If wb_addr == exe_inst rt, reload exe_store_data; reload exe_b as well if exe b_sel was 0.
  - The latched a_sel and b_sel are stored internally for this purpose.
- load_use_hazard = exe_valid & exe_mem_ren & exe_wb_addr!=0 & id_valid & (exe_wb_addr==id rs | exe_wb_addr==id rt).
- Simultaneous flush and stall: the flush wins and a bubble is loaded.
- Reset asserted mid-stall: a bubble is loaded; no state survives.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding and operand refresh as described above.
- Undefined:
  - Operands come from id_rs_data and id_rt_data only, with no refresh.
  - load_use_hazard also asserts when id_valid and rs or rt (nonzero) matches exe_wb_addr with exe_wb_en, or mem_fwd_addr with mem_fwd_en.

Test Plan:
- Reset then id_valid=1, inst=addi $3,$1,-4, rs_data=10, b_sel=1 -> next cycle exe_a=10, exe_b=32'hFFFFFFFC, exe_valid=1.
- rs=$5, mem_fwd_en=1, mem_fwd_addr=5, mem_fwd_data=7, wb_en=1, wb_addr=5, wb_data=9 -> exe_a=7. With mem_fwd_addr=0 and rs=$0 -> rf value used.
- sll, shamt=3, a_sel=1 -> exe_a=3. sllv, rs_data=32'h23, a_sel=2 -> exe_a=3.
- EX holds lw to $4; ID instruction reads rs=$4 -> load_use_hazard=1. Stall 1 cycle with wb_en=1, wb_addr=4, wb_data=32'h55 -> after stall, exe_a=32'h55.
- flush=1 and stall=1 together while exe_valid=1 -> next cycle exe_valid=0, exe_wb_en=0, exe_mem_wen=0, exe_inst=0.
- jal at id_pc=32'h00400010, b_sel=3 -> exe_b=32'h00400018. At id_pc=32'hFFFFFFFC -> exe_b=32'h00000004.
